// File: rtl/dither_pkg.sv
// Shared constants and types for the dithering accelerator.
// Frame geometry, luma weights and loader FSM states.
package dither_pkg;

  localparam int IMAGEX   = 64;
  localparam int IMAGEY   = 64;
  localparam int RGB_SIZE = 8;

  localparam int KR = 77;
  localparam int KG = 150;
  localparam int KB = 29;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pixel_ingest_unit_if.sv
// Pixel stream in / frame buffer write port out.
// master = pixel source side, slave = ingest unit.
interface pixel_ingest_unit_if #(
  parameter int DW = dither_pkg::RGB_SIZE,
  parameter int AW = $clog2(dither_pkg::IMAGEX * dither_pkg::IMAGEY)
);

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_g;
  logic [DW-1:0] in_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          frame_done;

  modport master (
    output start, in_valid, in_r, in_g, in_b,
    input  in_ready, wr_en, wr_addr, wr_data,
    input  busy, frame_done
  );

  modport slave (
    input  start, in_valid, in_r, in_g, in_b,
    output in_ready, wr_en, wr_addr, wr_data,
    output busy, frame_done
  );

endinterface

// File: rtl/rgb_to_luma.sv
// Two-stage RGB888 -> 8-bit luma, Y = (77R+150G+29B)>>8.
// Stage 1 holds the products, stage 2 the truncated sum.
module rgb_to_luma
  import dither_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                v_i,
  input  logic [RGB_SIZE-1:0] r_i,
  input  logic [RGB_SIZE-1:0] g_i,
  input  logic [RGB_SIZE-1:0] b_i,
  output logic                v_o,
  output logic [RGB_SIZE-1:0] y_o
);

  localparam int PW = 2 * RGB_SIZE;

  logic          v1_q;
  logic [PW-1:0] pr_q;
  logic [PW-1:0] pg_q;
  logic [PW-1:0] pb_q;
  logic [PW-1:0] sum;
  logic          v2_q;
  logic [RGB_SIZE-1:0] y_q;

  // stage 1: weighted channel products
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q <= 1'b0;
      pr_q <= '0;
      pg_q <= '0;
      pb_q <= '0;
    end else begin
      v1_q <= v_i;
      pr_q <= PW'(KR) * PW'(r_i);
      pg_q <= PW'(KG) * PW'(g_i);
      pb_q <= PW'(KB) * PW'(b_i);
    end
  end

  // max sum is 255*256 = 65280, so PW bits never overflow
  assign sum = pr_q + pg_q + pb_q;

  // stage 2: keep the high byte, hold it between samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      v2_q <= 1'b0;
      y_q  <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) y_q <= sum[PW-1:RGB_SIZE];
    end
  end

  assign v_o = v2_q;
  assign y_o = y_q;

endmodule

// File: rtl/pixel_ingest_unit.sv
// Frame loader: accepts a raster RGB stream, writes luma
// sequentially into the frame buffer, pulses frame_done.
module pixel_ingest_unit #(
  parameter int IMAGEX = dither_pkg::IMAGEX,
  parameter int IMAGEY = dither_pkg::IMAGEY
) (
  input  logic                clk,
  input  logic                rst,
  pixel_ingest_unit_if.slave  bus
);

  import dither_pkg::*;

  localparam int IMAGE_SIZE = IMAGEX * IMAGEY;
  localparam int ADDR_W     = $clog2(IMAGE_SIZE);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(IMAGE_SIZE - 1);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_LOAD  = 2'(LOAD);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]   wr_q, wr_d;
  logic                ready;
  logic                accept;
  logic                luma_v;
  logic [RGB_SIZE-1:0] luma_y;

  assign ready  = (state_q == S_LOAD);
  assign accept = bus.in_valid && ready;

  rgb_to_luma u_luma (
    .clk (clk),
    .rst (rst),
    .v_i (accept),
    .r_i (bus.in_r),
    .g_i (bus.in_g),
    .b_i (bus.in_b),
    .v_o (luma_v),
    .y_o (luma_y)
  );

  // next state and counters; DRAIN ends on the final write
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          acc_d   = '0;
          wr_d    = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          acc_d = acc_q + 1'b1;
          if (acc_q == LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (luma_v && wr_q == LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (luma_v) wr_d = wr_d + 1'b1;
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.wr_en      = luma_v;
  assign bus.wr_addr    = wr_q;
  assign bus.wr_data    = luma_y;

endmodule

// File: tb/tb_pixel_ingest_unit.sv
// Directed + randomized bench for pixel_ingest_unit,
// checked against an event-scheduled reference model.
module tb_pixel_ingest_unit;

  localparam int N     = 64 * 64;
  localparam int GUARD = 30000;

  logic clk = 1'b0;
  logic rst_n;

  pixel_ingest_unit_if bus ();

  pixel_ingest_unit dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  always #10 clk = ~clk;

  typedef struct {
    int addr;
    int y;
    int due;
  } wr_t;

  wr_t q[$];
  int  ncmp = 0;
  int  nbad = 0;
  int  E = 0;
  bit  active = 1'b0;
  bit  loading = 1'b0;
  int  cnt = 0;
  int  done_edge = -1;
  int  end_edge = -1;
  int  frames_exp = 0;
  int  frames_seen = 0;
  int  got_y[N];

  int cr[6] = '{255, 255, 0,   0,   128, 0};
  int cg[6] = '{255, 0,   255, 0,   128, 0};
  int cb[6] = '{255, 0,   0,   255, 128, 0};
  int cy[6] = '{255, 76,  149, 28,  128, 0};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s: got %0d expected %0d",
             tag, got, exp);
    end
  endtask

  function automatic int luma(int r, int g, int b);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  task automatic rand_px();
    bus.in_r = 8'($urandom_range(255));
    bus.in_g = 8'($urandom_range(255));
    bus.in_b = 8'($urandom_range(255));
  endtask

  // one clock: schedule the model's events, then check
  task automatic tick();
    bit  was_idle;
    wr_t w;
    was_idle = !active;
    E++;
    if (!rst_n) begin
      active    = 1'b0;
      loading   = 1'b0;
      q.delete();
      done_edge = -1;
      end_edge  = -1;
    end else begin
      if (active && E == end_edge) active = 1'b0;
      if (was_idle && bus.start) begin
        active  = 1'b1;
        loading = 1'b1;
        cnt     = 0;
      end else if (loading && bus.in_valid) begin
        w.addr = cnt;
        w.y    = luma(bus.in_r, bus.in_g, bus.in_b);
        w.due  = E + 1;
        q.push_back(w);
        cnt++;
        if (cnt == N) begin
          loading   = 1'b0;
          done_edge = E + 2;
          end_edge  = E + 3;
          frames_exp++;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("busy", bus.busy, active);
    chk("in_ready", bus.in_ready, loading);
    chk("frame_done", bus.frame_done, E == done_edge);
    if (bus.frame_done === 1'b1) frames_seen++;
    if (q.size() > 0 && q[0].due == E) begin
      w = q.pop_front();
      chk("wr_en", bus.wr_en, 1);
      chk("wr_addr", bus.wr_addr, w.addr);
      chk("wr_data", bus.wr_data, w.y);
      got_y[w.addr] = int'(bus.wr_data);
    end else begin
      chk("wr_en_idle", bus.wr_en, 0);
    end
  endtask

  task automatic run_frame(input int duty);
    int guard;
    guard = 0;
    bus.start = 1'b1;
    tick();
    while (loading && guard < GUARD) begin
      bus.in_valid = ($urandom_range(99) < duty);
      rand_px();
      bus.start = ($urandom_range(3) == 0);
      tick();
      guard++;
    end
    bus.start = 1'b0;
    while (active && guard < GUARD) begin
      bus.in_valid = 1'($urandom_range(1));
      rand_px();
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("frame_bound", guard < GUARD, 1);
  endtask

  initial begin
    foreach (got_y[i]) got_y[i] = -1;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_r     = '0;
    bus.in_g     = '0;
    bus.in_b     = '0;
    tick();
    tick();
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);

    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    rand_px();
    tick();
    tick();
    bus.in_valid = 1'b0;

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_r = 8'(cr[i]);
      bus.in_g = 8'(cg[i]);
      bus.in_b = 8'(cb[i]);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 6; i++)
      chk("colour", got_y[i], cy[i]);

    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      rand_px();
      tick();
    end
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'($urandom_range(1));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("midrst_wr_addr", bus.wr_addr, 0);
    chk("midrst_frames", frames_seen, 0);

    run_frame(100);
    run_frame(50);
    run_frame(50);
    tick();
    chk("frames", frames_seen, frames_exp);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
